// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX scheduler.
// The UART_TX_CRLF_EN build uses ASCII_CR and ASCII_LF to expand LF into CR+LF.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; pointers wrap modulo DEPTH (power of two).
// Push when full is accepted only if a pop happens in the same cycle (caller guarantees).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues toggle-encoded MMIO TX writes and hands bytes to the serializer via start/busy.
// Optional UART_TX_CRLF_EN: every LF popped is sent as CR followed by LF.
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_enable,
    input  logic [8:0] uart_tx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       uart_tx_sending,
    output logic       fifo_full,
    output logic       tx_overflow
);

    tx_state_e      state, state_nxt;
    logic           last_toggle;
    logic           push_evt;
    logic           push;
    logic           pop;
    logic           load;
    logic [7:0]     load_byte;
    logic [7:0]     head;
    logic [PTR_W:0] count;
    logic           empty;
`ifdef UART_TX_CRLF_EN
    logic           pending_lf;
    logic           lf_set;
    logic           lf_clr;
`endif

    // A write is any change of bit 8 seen while the CPU clock is enabled.
    assign push_evt = clk_enable && (uart_tx_data[8] != last_toggle);
    assign push     = push_evt && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (uart_tx_data[7:0]),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = head;
`ifdef UART_TX_CRLF_EN
        lf_set    = 1'b0;
        lf_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef UART_TX_CRLF_EN
                if (pending_lf) begin
                    // Second half of CR+LF: no pop, the LF is already held.
                    load      = 1'b1;
                    load_byte = ASCII_LF;
                    lf_clr    = 1'b1;
                    state_nxt = START;
                end else
`endif
                if (count != '0) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = START;
`ifdef UART_TX_CRLF_EN
                    if (head == ASCII_LF) begin
                        load_byte = ASCII_CR;
                        lf_set    = 1'b1;
                    end
`endif
                end
            end
            START: if (tx_busy)  state_nxt = DRAIN;
            DRAIN: if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start    <= 1'b0;
            tx_byte     <= 8'h00;
            tx_overflow <= 1'b0;
            last_toggle <= 1'b1;
        end else begin
            tx_start <= (state_nxt == START);
            if (load) tx_byte <= load_byte;
            if (clk_enable) last_toggle <= uart_tx_data[8];
            if (push_evt && fifo_full && !pop) tx_overflow <= 1'b1;
        end
    end

`ifdef UART_TX_CRLF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         pending_lf <= 1'b0;
        else if (lf_set) pending_lf <= 1'b1;
        else if (lf_clr) pending_lf <= 1'b0;
    end

    assign uart_tx_sending = !empty || (state != IDLE) || pending_lf;
`else
    assign uart_tx_sending = !empty || (state != IDLE);
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small serializer model on the busy side.
// Honours UART_TX_CRLF_EN when checking the LF expansion.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_enable;
    logic [8:0] uart_tx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       uart_tx_sending;
    logic       fifo_full;
    logic       tx_overflow;

    int n_vec = 0;
    int n_err = 0;

    // Serializer model controls
    int         busy_len = 3;
    logic       hold = 1'b0;
    logic       mute = 1'b0;
    int         busy_cnt = 0;
    logic       prev_start = 1'b0;
    int         rises = 0;
    logic [7:0] sent_q[$];
    logic       tog;

    uart_tx_scheduler #(.FIFO_DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_enable      (clk_enable),
        .uart_tx_data    (uart_tx_data),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_byte         (tx_byte),
        .uart_tx_sending (uart_tx_sending),
        .fifo_full       (fifo_full),
        .tx_overflow     (tx_overflow)
    );

    always #5 clk = ~clk;

    // Serializer: accepts on tx_start while idle, stays busy busy_len cycles (or while hold).
    always @(negedge clk) begin
        if (rst) begin
            tx_busy    = 1'b0;
            busy_cnt   = 0;
            prev_start = 1'b0;
        end else begin
            if (tx_start && !prev_start) rises++;
            prev_start = tx_start;
            if (tx_start && !tx_busy && !mute) begin
                sent_q.push_back(tx_byte);
                busy_cnt = busy_len;
                tx_busy  = 1'b1;
            end else if (tx_busy && !hold) begin
                if (busy_cnt > 1) busy_cnt--;
                else begin
                    busy_cnt = 0;
                    tx_busy  = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] sent_at(input int i);
        if (i < sent_q.size()) return sent_q[i];
        return 8'hxx;
    endfunction

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        tog          = ~tog;
        uart_tx_data = {tog, b};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (!uart_tx_sending && !tx_busy) break;
        end
        chk("idle", {31'd0, uart_tx_sending}, 32'd0);
    endtask

    initial begin
        int base;
        int r0;
        rst          = 1'b1;
        clk_enable   = 1'b1;
        tog          = 1'b1;
        uart_tx_data = 9'h1FF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_byte", {24'd0, tx_byte}, 32'h00);
        chk("rst_ovf", {31'd0, tx_overflow}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_sending", {31'd0, uart_tx_sending}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_phantom", {31'd0, uart_tx_sending}, 32'd0);

        // Single write, long busy
        busy_len = 10;
        base = sent_q.size();
        wr(8'h41);
        chk("single_start_c1", {31'd0, tx_start}, 32'd0);
        chk("single_sending", {31'd0, uart_tx_sending}, 32'd1);
        @(posedge clk); #1;
        chk("single_start_c2", {31'd0, tx_start}, 32'd1);
        chk("single_byte", {24'd0, tx_byte}, 32'h41);
        @(posedge clk); #1;
        chk("single_start_drop", {31'd0, tx_start}, 32'd0);
        chk("single_sending_busy", {31'd0, uart_tx_sending}, 32'd1);
        wait_idle(100);
        chk("single_cnt", sent_q.size() - base, 32'd1);
        chk("single_sent", {24'd0, sent_at(base)}, 32'h41);

        // Burst of three
        busy_len = 3;
        base = sent_q.size();
        r0   = rises;
        wr(8'h31);
        wr(8'h32);
        wr(8'h33);
        wait_idle(100);
        chk("burst_cnt", sent_q.size() - base, 32'd3);
        chk("burst_rises", rises - r0, 32'd3);
        chk("burst0", {24'd0, sent_at(base)}, 32'h31);
        chk("burst1", {24'd0, sent_at(base + 1)}, 32'h32);
        chk("burst2", {24'd0, sent_at(base + 2)}, 32'h33);

        // Toggle flips while clk_enable is low
        base = sent_q.size();
        @(negedge clk);
        clk_enable   = 1'b0;
        tog          = ~tog;
        uart_tx_data = {tog, 8'h55};
        repeat (3) @(posedge clk);
        #1;
        chk("gated_no_push", {31'd0, uart_tx_sending}, 32'd0);
        @(negedge clk);
        clk_enable = 1'b1;
        @(posedge clk); #1;
        chk("gated_push", {31'd0, uart_tx_sending}, 32'd1);
        wait_idle(100);
        chk("gated_cnt", sent_q.size() - base, 32'd1);
        chk("gated_byte", {24'd0, sent_at(base)}, 32'h55);

        // Fill, overflow, then push with a simultaneous pop at full
        busy_len = 1;
        hold     = 1'b1;
        base = sent_q.size();
        wr(8'h5A);
        for (int i = 0; i < 16; i++) wr(8'h60 + 8'(i));
        chk("fill_full", {31'd0, fifo_full}, 32'd1);
        chk("fill_no_ovf", {31'd0, tx_overflow}, 32'd0);
        wr(8'hEE);
        chk("ovf_set", {31'd0, tx_overflow}, 32'd1);
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        hold = 1'b0;
        @(negedge clk);
        wr(8'h77);
        chk("pushpop_full", {31'd0, fifo_full}, 32'd1);
        busy_len = 2;
        wait_idle(400);
        chk("ovf_sticky", {31'd0, tx_overflow}, 32'd1);
        chk("fill_cnt", sent_q.size() - base, 32'd18);
        chk("fill_first", {24'd0, sent_at(base)}, 32'h5A);
        for (int i = 0; i < 16; i++)
            chk("fill_seq", {24'd0, sent_at(base + 1 + i)}, {24'd0, 8'h60 + 8'(i)});
        chk("fill_last", {24'd0, sent_at(base + 17)}, 32'h77);

        // Reset while stuck in START with 4 queued
        mute = 1'b1;
        base = sent_q.size();
        for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
        repeat (2) @(posedge clk);
        #1;
        chk("mid_start", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        rst          = 1'b1;
        tog          = 1'b1;
        uart_tx_data = 9'h1FF;
        #1;
        chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_sending", {31'd0, uart_tx_sending}, 32'd0);
        chk("mid_rst_ovf", {31'd0, tx_overflow}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        mute = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_none_sent", sent_q.size() - base, 32'd0);
        chk("mid_sending", {31'd0, uart_tx_sending}, 32'd0);

        // LF handling
        busy_len = 2;
        base = sent_q.size();
        wr(8'h0A);
        wait_idle(100);
`ifdef UART_TX_CRLF_EN
        chk("lf_cnt", sent_q.size() - base, 32'd2);
        chk("lf_cr", {24'd0, sent_at(base)}, 32'h0D);
        chk("lf_lf", {24'd0, sent_at(base + 1)}, 32'h0A);
`else
        chk("lf_cnt", sent_q.size() - base, 32'd1);
        chk("lf_lf", {24'd0, sent_at(base)}, 32'h0A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sits between the MMIO register block and the UART serializer.
- Detects CPU writes to the UART TX MMIO register through its toggle-encoded output (bit 8 flips on every write) and queues each byte in a FIFO.
- Feeds queued bytes to the serializer over a start/busy handshake.
- Returns uart_tx_sending to the MMIO block as a "transmit in progress" status.

Parameters:
- FIFO_DEPTH, 16, byte queue depth; power of two, >= 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clk_enable  in  1  CPU clock enable, same signal that gates MMIO writes
- uart_tx_data  in  9  from MMIO: [8] write toggle, [7:0] byte
- tx_busy  in  1  serializer busy, high from accepting a byte until its stop bit completes
- tx_start  out  1  request to serializer; tx_byte is valid while high
- tx_byte  out  8  byte to serialize
- uart_tx_sending  out  1  high when FIFO non-empty OR FSM not IDLE
- fifo_full  out  1  FIFO count == FIFO_DEPTH
- tx_overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (async, immediate) clears all of the following:
  - tx_start=0, tx_byte=0x00, tx_overflow=0
  - FIFO empty (count=0, pointers=0), FSM=IDLE
  - last_toggle=1, which matches the MMIO register's power-up value of all ones
- Push detection:
  - Active on a clk edge with clk_enable=1 and uart_tx_data[8] != last_toggle.
  - last_toggle <= uart_tx_data[8].
  - If FIFO not full, or a pop occurs in the same cycle: push uart_tx_data[7:0].
  - Otherwise drop the byte and set tx_overflow. tx_overflow is cleared only by rst.
  - Toggle sampling is gated by clk_enable. The FIFO pop side and the FSM run every clk.
- FIFO:
  - Synchronous, registered count; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged, including at full.
  - Pop is legal only when count != 0.
  - A byte pushed into an empty FIFO is first poppable on the following cycle (minimum 1 cycle push-to-tx_start).
- FSM states: IDLE, START, DRAIN.
  - IDLE: if count != 0, pop, tx_byte <= head, go to START.
  - START: tx_start=1. When tx_busy=1, drop tx_start and go to DRAIN. Stays in START indefinitely while tx_busy=0.
  - DRAIN: wait for tx_busy=0, then go to IDLE. Back-to-back bytes therefore have one IDLE cycle between them.
  - tx_byte stays stable from entry to START until the next pop.
  - tx_start is registered and is high only in START.
- Reset mid-byte: tx_start drops immediately. The serializer is reset by the same rst. Queued bytes are lost.
- uart_tx_sending is combinational from registered state, with no added latency.

Optional Feature:
- Macro: UART_TX_CRLF_EN.
- Defined: on popping 0x0A, the FSM first sends 0x0D (full START/DRAIN cycle), then sends 0x0A without a second pop. A pending_lf flag holds the pending 0x0A and keeps uart_tx_sending high until both bytes are sent. Reset clears pending_lf.
- Undefined: bytes are sent verbatim, and pending_lf logic is absent.

Decomposition:
- Package uart_tx_pkg: state enum (IDLE, START, DRAIN), constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH), with ports push, pop, din, dout, count, full, empty.

Test Plan:
- Single write: toggle 1->0 with byte 0x41, tx_busy held high for 10 cycles after tx_start → tx_start high from cycle 2 until tx_busy=1, tx_byte=0x41; uart_tx_sending high until tx_busy falls, then low.
- Burst of 3 writes (0x31, 0x32, 0x33) on consecutive clk_enable cycles → tx_byte sequence 0x31, 0x32, 0x33 in order, exactly one tx_start per byte.
- Toggle flip with clk_enable=0, then clk_enable=1 → no push while disabled, exactly one push once enabled.
- Fill FIFO_DEPTH=16 bytes with tx_busy stuck high, then one more write → fifo_full=1, tx_overflow=1, 17th byte never transmitted; push with a simultaneous pop at full is accepted.
- Assert rst while in START with 4 bytes queued → tx_start=0 asynchronously, uart_tx_sending=0, no bytes sent after release.
- UART_TX_CRLF_EN defined, write 0x0A → serializer receives 0x0D then 0x0A. Macro undefined → only 0x0A.
